// File: rtl/btn_cond_pkg.sv
// Shared constants for the panel input conditioner: channel count, channel
// indices and the default debounce length.
package btn_cond_pkg;

    localparam int NUM_BTNS      = 4;
    localparam int IDX_S         = 0;
    localparam int IDX_R         = 1;
    localparam int IDX_G         = 2;
    localparam int IDX_B         = 3;
    localparam int DB_CYCLES_DEF = 4;

    typedef logic [NUM_BTNS-1:0] btn_vec_t;

endpackage

// File: rtl/btn_debounce.sv
// One conditioning channel: optional two-flop synchronizer (BTN_COND_SYNC_EN),
// stability counter, debounced level and registered rising-edge pulse.
module btn_debounce
    import btn_cond_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic Clk,
    input  logic Rst,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);

    localparam int              CW      = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DB_CYCLES - 1);

    logic samp_s;

`ifdef BTN_COND_SYNC_EN
    logic sync1_q;
    logic sync2_q;

    // Two-stage synchronizer for the asynchronous raw input
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    assign samp_s = sync2_q;
`else
    assign samp_s = raw_i;
`endif

    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rise_q, rise_d;

    // Any sample matching the current level restarts the count
    always_comb begin
        stable_d = stable_q;
        cnt_d    = {CW{1'b0}};
        if (samp_s == stable_q) begin
            cnt_d = {CW{1'b0}};
        end else if (cnt_q == CNT_MAX) begin
            stable_d = samp_s;
            cnt_d    = {CW{1'b0}};
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        rise_d = stable_d & ~stable_q;
    end

    // Debounce state and output pulse registers
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            stable_q <= 1'b0;
            cnt_q    <= {CW{1'b0}};
            rise_q   <= 1'b0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
        end
    end

    assign level_o = stable_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/btn_conditioner.sv
// Panel input conditioner: debounced start level plus one-cycle colour press
// pulses. Define BTN_COND_SYNC_EN to include the input synchronizers.
module btn_conditioner
    import btn_cond_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic Clk,
    input  logic Rst,
    input  logic BtnS,
    input  logic BtnR,
    input  logic BtnG,
    input  logic BtnB,
    output logic S,
    output logic R,
    output logic G,
    output logic B
);

    btn_vec_t raw_s;
    btn_vec_t level_s;
    btn_vec_t rise_s;

    assign raw_s[IDX_S] = BtnS;
    assign raw_s[IDX_R] = BtnR;
    assign raw_s[IDX_G] = BtnG;
    assign raw_s[IDX_B] = BtnB;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
        btn_debounce #(
            .DB_CYCLES (DB_CYCLES)
        ) u_db (
            .Clk     (Clk),
            .Rst     (Rst),
            .raw_i   (raw_s[i]),
            .level_o (level_s[i]),
            .rise_o  (rise_s[i])
        );
    end

    // Start is a level; colours are press pulses so releases are ignored
    assign S = level_s[IDX_S];
    assign R = rise_s[IDX_R];
    assign G = rise_s[IDX_G];
    assign B = rise_s[IDX_B];

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner with DB_CYCLES = 4; expected pulse
// cycles are queued when a press is driven and checked at every falling edge.
module tb_btn_conditioner;

`ifdef BTN_COND_SYNC_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif
    localparam int NEVER = 1 << 30;

    typedef struct {
        int         cyc;
        logic [2:0] rgb;
    } exp_t;

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    logic BtnS = 1'b0, BtnR = 1'b0, BtnG = 1'b0, BtnB = 1'b0;
    logic S, R, G, B;

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    btn_conditioner #(.DB_CYCLES(4)) dut (
        .Clk(Clk), .Rst(Rst),
        .BtnS(BtnS), .BtnR(BtnR), .BtnG(BtnG), .BtnB(BtnB),
        .S(S), .R(R), .G(G), .B(B)
    );

    initial forever #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    function automatic exp_t mk(input int c, input logic [2:0] v);
        exp_t e;
        e.cyc = c;
        e.rgb = v;
        return e;
    endfunction

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({S, R, G, B} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_t0 got SRGB=%b required 0000", {S, R, G, B});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            n_cmp++;
            if ({S, R, G, B} !== 4'b0000) begin
                n_err++;
                $display("FAIL reset_hold cyc=%0d got SRGB=%b required 0000", cyc, {S, R, G, B});
            end
        end
        Rst = 1'b1;
    endtask

    task automatic test_clean_press();
        logic [2:0] exp_rgb;
        for (int i = 0; i < 30; i++) begin
            @(negedge Clk);
            exp_rgb = 3'b000;
            if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
                exp_rgb = sb_q[0].rgb;
                void'(sb_q.pop_front());
            end
            n_cmp++;
            if ({R, G, B} !== exp_rgb || S !== 1'b0) begin
                n_err++;
                $display("FAIL clean_press cyc=%0d got S,RGB=%b,%b required 0,%b", cyc, S, {R, G, B}, exp_rgb);
            end
            if (i == 0) begin BtnR = 1'b1; sb_q.push_back(mk(cyc + 1 + LAT, 3'b100)); end
            if (i == 10) BtnR = 1'b0;
        end
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL clean_press_pending got %0d pending pulses required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_bounce();
        logic [2:0] exp_rgb;
        for (int i = 0; i < 26; i++) begin
            @(negedge Clk);
            exp_rgb = 3'b000;
            if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
                exp_rgb = sb_q[0].rgb;
                void'(sb_q.pop_front());
            end
            n_cmp++;
            if ({R, G, B} !== exp_rgb || S !== 1'b0) begin
                n_err++;
                $display("FAIL bounce cyc=%0d got S,RGB=%b,%b required 0,%b", cyc, S, {R, G, B}, exp_rgb);
            end
            if (i <= 3) BtnG = (i % 2 == 0);
            if (i == 4) begin BtnG = 1'b1; sb_q.push_back(mk(cyc + 1 + LAT, 3'b010)); end
            if (i == 15) BtnG = 1'b0;
        end
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL bounce_pending got %0d pending pulses required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_glitch();
        logic [2:0] exp_rgb;
        for (int i = 0; i < 28; i++) begin
            @(negedge Clk);
            exp_rgb = 3'b000;
            if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
                exp_rgb = sb_q[0].rgb;
                void'(sb_q.pop_front());
            end
            n_cmp++;
            if ({R, G, B} !== exp_rgb || S !== 1'b0) begin
                n_err++;
                $display("FAIL glitch cyc=%0d got S,RGB=%b,%b required 0,%b", cyc, S, {R, G, B}, exp_rgb);
            end
            if (i == 0) BtnB = 1'b1;
            if (i == 3) BtnB = 1'b0;
            // Full press afterwards: early pulse means the count was not cleared
            if (i == 6) begin BtnB = 1'b1; sb_q.push_back(mk(cyc + 1 + LAT, 3'b001)); end
            if (i == 16) BtnB = 1'b0;
        end
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL glitch_pending got %0d pending pulses required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_start_switch();
        int   s_rise = NEVER;
        int   s_fall = NEVER;
        logic exp_s;
        for (int i = 0; i < 36; i++) begin
            @(negedge Clk);
            exp_s = (cyc >= s_rise) && (cyc < s_fall);
            n_cmp++;
            if (S !== exp_s || {R, G, B} !== 3'b000) begin
                n_err++;
                $display("FAIL start_switch cyc=%0d got S,RGB=%b,%b required %b,000", cyc, S, {R, G, B}, exp_s);
            end
            if (i == 0) begin BtnS = 1'b1; s_rise = cyc + 1 + LAT; end
            if (i == 20) begin BtnS = 1'b0; s_fall = cyc + 1 + LAT; end
        end
    endtask

    task automatic test_simultaneous();
        logic [2:0] exp_rgb;
        for (int i = 0; i < 22; i++) begin
            @(negedge Clk);
            exp_rgb = 3'b000;
            if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
                exp_rgb = sb_q[0].rgb;
                void'(sb_q.pop_front());
            end
            n_cmp++;
            if ({R, G, B} !== exp_rgb || S !== 1'b0) begin
                n_err++;
                $display("FAIL simultaneous cyc=%0d got S,RGB=%b,%b required 0,%b", cyc, S, {R, G, B}, exp_rgb);
            end
            if (i == 0) begin
                BtnR = 1'b1;
                BtnB = 1'b1;
                sb_q.push_back(mk(cyc + 1 + LAT, 3'b101));
            end
            if (i == 10) begin BtnR = 1'b0; BtnB = 1'b0; end
        end
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL simultaneous_pending got %0d pending pulses required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        int         s_rise = NEVER;
        int         r1     = LAT + 1;
        int         rel1   = LAT + 3;
        int         r2     = LAT + 6;
        int         rel2   = LAT + 8;
        logic [2:0] exp_rgb;
        logic       exp_s;
        for (int i = 0; i < rel2 + LAT + 10; i++) begin
            @(negedge Clk);
            exp_rgb = 3'b000;
            if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
                exp_rgb = sb_q[0].rgb;
                void'(sb_q.pop_front());
            end
            exp_s = (cyc >= s_rise);
            n_cmp++;
            if ({R, G, B} !== exp_rgb || S !== exp_s) begin
                n_err++;
                $display("FAIL reset_mid cyc=%0d got S,RGB=%b,%b required %b,%b", cyc, S, {R, G, B}, exp_s, exp_rgb);
            end
            if (i == 0) begin
                BtnS = 1'b1;
                BtnR = 1'b1;
                s_rise = cyc + 1 + LAT;
                sb_q.push_back(mk(cyc + 1 + LAT, 3'b100));
            end
            // Reset while S and the R pulse are high, and again mid-count
            if (i == r1 || i == r2) begin
                #2;
                Rst = 1'b0;
                #1;
                n_cmp++;
                if ({S, R, G, B} !== 4'b0000) begin
                    n_err++;
                    $display("FAIL reset_async cyc=%0d got SRGB=%b required 0000", cyc, {S, R, G, B});
                end
                s_rise = NEVER;
                sb_q.delete();
            end
            if (i == rel1 || i == rel2) begin
                Rst = 1'b1;
                s_rise = cyc + 1 + LAT;
                sb_q.push_back(mk(cyc + 1 + LAT, 3'b100));
            end
        end
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL reset_mid_pending got %0d pending pulses required 0", sb_q.size());
            sb_q.delete();
        end
        BtnS = 1'b0;
        BtnR = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_start_switch();
        test_simultaneous();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
